// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM state encodings and port identifiers shared by the arbiter files
package mem_port_arbiter_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: both request ports plus the shared memory bus
interface mem_port_arbiter_if #(parameter int WIDTH = 32);
  logic req0, req1, we0, we1;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, owner, busy, mem_en, mem_we;
  logic [WIDTH-1:0] rdata, mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mux2.sv
// mux2: two-input word multiplexer, b selected when sel is high
module mux2 #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-port winner select, round-robin on last_gnt or fixed priority to port 0
module rr_arb2 import mem_port_arbiter_pkg::*; #(parameter int FIXED_PRIO = 0) (
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic win_o,
  output logic gnt0_o,
  output logic gnt1_o
);
  assign win_o  = (req0_i && req1_i) ? ((FIXED_PRIO != 0) ? PORT_D : ~last_gnt_i)
                                     : (req1_i ? PORT_I : PORT_D);
  assign gnt0_o = en_i && req0_i && (win_o == PORT_D);
  assign gnt1_o = en_i && req1_i && (win_o == PORT_I);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the data and instruction ports
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..4");
  end
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic owner_q, owner_d, last_gnt_q, last_gnt_d, we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, addr_sel, wdata_sel;
  logic win, gnt0, gnt1, idle, issue, resp;
  // gnt is masked while reset is held so all outputs read 0 during reset
  assign idle  = (state_q == ST_IDLE) && !reset;
  assign issue = state_q == ST_ISSUE;
  assign resp  = state_q == ST_RESP;
  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .en_i(idle), .req0_i(bus.req0), .req1_i(bus.req1), .last_gnt_i(last_gnt_q),
    .win_o(win), .gnt0_o(gnt0), .gnt1_o(gnt1)
  );
  mux2 #(.WIDTH(WIDTH)) u_addr_mux (.a_i(bus.addr0), .b_i(bus.addr1), .sel_i(win), .y_o(addr_sel));
  mux2 #(.WIDTH(WIDTH)) u_wdata_mux (.a_i(bus.wdata0), .b_i(bus.wdata1), .sel_i(win), .y_o(wdata_sel));
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (gnt0 || gnt1) begin
      state_d    = ST_ISSUE;
      owner_d    = win;
      last_gnt_d = win;
      we_d       = win ? bus.we1 : bus.we0;
      addr_d     = addr_sel;
      wdata_d    = wdata_sel;
    end else if (issue) begin
      state_d = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
      cnt_d   = CNT_INIT;
    end else if (state_q == ST_WAIT) begin
      state_d = (cnt_q == '0) ? ST_RESP : ST_WAIT;
      cnt_d   = cnt_q - CW'(1);
    end else if (resp) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= PORT_D;
      last_gnt_q <= PORT_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end
  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.owner     = owner_q;
  assign bus.busy      = state_q != ST_IDLE;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rvalid0   = resp && (owner_q == PORT_D);
  assign bus.rvalid1   = resp && (owner_q == PORT_I);
  assign bus.rdata     = resp ? bus.mem_rdata : '0;
endmodule
